microsequencer: RTL

- Next-address generator for the microprogrammed control unit; drives the 7-bit microstore index each cycle.
- Takes next-state and condition fields from the current microinstruction, plus condition and dispatch inputs from the datapath and instruction decoder.
- Registers the next microstore address; the microstore itself is combinational.
- Includes a small return-address stack for microsubroutines and sticky error flags for illegal sequencing.

---
 rtl/microsequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// microsequencer : next-microstore-address generator with return stack
//                  and sticky sequencing-error flags.
// Rev 1.0
// ============================================================================
module microsequencer #(
  parameter int ADDR_W      = 7,
  parameter int ROM_LAST    = 95,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        ns,
  input  logic [1:0]        cond_sel,
  input  logic              cond_inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] dispatch_addr,
  input  logic              moc,
  input  logic              cond_pass,
  input  logic              list_empty,
  output logic [ADDR_W-1:0] index,
  output logic              stack_err,
  output logic              addr_err
);

  localparam int c_SP_W = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] c_NS_DISPATCH = 3'b000;
  localparam logic [2:0] c_NS_FETCH    = 3'b001;
  localparam logic [2:0] c_NS_INCR     = 3'b010;
  localparam logic [2:0] c_NS_BRANCH   = 3'b011;
  localparam logic [2:0] c_NS_BR_DISP  = 3'b100;
  localparam logic [2:0] c_NS_CALL     = 3'b101;
  localparam logic [2:0] c_NS_RETURN   = 3'b110;
  localparam logic [2:0] c_NS_WAIT     = 3'b111;

  logic [ADDR_W-1:0] index_q, index_d;
  logic [c_SP_W-1:0] sp_q, sp_d;
  logic              stack_err_q, stack_err_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              w_cond_raw;
  logic              w_cond;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_pop_val;
  logic [ADDR_W-1:0] w_next;
  logic              w_push;
  logic              w_pop;
  logic              w_stk_fault;
  logic              w_addr_bad;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (sp_q == c_SP_W'(STACK_DEPTH));
  assign w_empty = (sp_q == '0);
  assign w_inc   = index_q + ADDR_W'(1);

  always_comb begin
    w_cond_raw = 1'b1;
    case (cond_sel)
      2'b00:   w_cond_raw = moc;
      2'b01:   w_cond_raw = cond_pass;
      2'b10:   w_cond_raw = list_empty;
      default: w_cond_raw = 1'b1;
    endcase
    w_cond = w_cond_raw ^ cond_inv;
  end

  // Top-of-stack read: entry sp-1 holds the most recent push.
  always_comb begin
    w_pop_val = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      if (sp_q == c_SP_W'(k + 1)) begin
        w_pop_val = stack_q[k];
      end
    end
  end

  always_comb begin
    w_next      = index_q;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_stk_fault = 1'b0;
    case (ns)
      c_NS_DISPATCH: w_next = dispatch_addr;
      c_NS_FETCH:    w_next = '0;
      c_NS_INCR:     w_next = w_inc;
      c_NS_BRANCH:   w_next = w_cond ? cr_addr : w_inc;
      c_NS_BR_DISP:  w_next = w_cond ? cr_addr : dispatch_addr;
      c_NS_CALL: begin
        w_next      = cr_addr;
        w_push      = !w_full;
        w_stk_fault = w_full;
      end
      c_NS_RETURN: begin
        w_next      = w_empty ? '0 : w_pop_val;
        w_pop       = !w_empty;
        w_stk_fault = w_empty;
      end
      c_NS_WAIT:     w_next = moc ? w_inc : index_q;
      default:       w_next = index_q;
    endcase
  end

  // Zero-extended compare keeps the check meaningful for any ROM_LAST.
  assign w_addr_bad = ({1'b0, w_next} > (ADDR_W + 1)'(ROM_LAST));

  always_comb begin
    index_d     = w_addr_bad ? '0 : w_next;
    sp_d        = sp_q;
    if (w_push) begin
      sp_d = sp_q + c_SP_W'(1);
    end else if (w_pop) begin
      sp_d = sp_q - c_SP_W'(1);
    end
    stack_err_d = stack_err_q | w_stk_fault;
    addr_err_d  = addr_err_q | w_addr_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q     <= '0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else if (!stall) begin
      index_q     <= index_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Stack contents need no reset; only sp defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!stall && w_push) begin
      for (int k = 0; k < STACK_DEPTH; k++) begin
        if (sp_q == c_SP_W'(k)) begin
          stack_q[k] <= w_inc;
        end
      end
    end
  end

  assign index     = index_q;
  assign stack_err = stack_err_q;
  assign addr_err  = addr_err_q;

endmodule
`default_nettype wire
